// File: rtl/count_pkg.sv
// ----------------------------------------------------------------------------
// count_pkg
//   Shared definitions for the set-bit counter pair (count_ctrl / count_dp).
//   Holds the controller state encoding that both blocks decode, so neither
//   block carries a private copy of it.
// ----------------------------------------------------------------------------
package count_pkg;

    // Controller sequencing: IDLE -> COUNT -> CHECK -> (COUNT | DONE) -> IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        COUNT = 2'b01,
        CHECK = 2'b10,
        DONE  = 2'b11
    } cnt_state_e;

endpackage : count_pkg

// File: rtl/count_operand_buf.sv
// ----------------------------------------------------------------------------
// count_operand_buf
//   One-entry operand buffer on a valid/ready input handshake.
//   Ports:
//     clk, rst              clock, asynchronous active-high reset
//     in_valid / in_data    offered operand
//     in_ready              operand is accepted this cycle
//     pop                   consumer takes the held operand this cycle
//     pend_valid/pend_data  held operand
//   A pop frees the slot in the same cycle, so a new operand can be accepted
//   while the held one is being taken (full throughput with one entry).
// ----------------------------------------------------------------------------
module count_operand_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    input  logic         pop,
    output logic         pend_valid,
    output logic [W-1:0] pend_data
);

    logic         pend_valid_q, pend_valid_d;
    logic [W-1:0] pend_data_q,  pend_data_d;

    assign in_ready   = !pend_valid_q || pop;
    assign pend_valid = pend_valid_q;
    assign pend_data  = pend_data_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (pop) begin
            pend_valid_d = 1'b0;
        end
        // Accept after pop: a refill in the pop cycle keeps the slot full.
        if (in_valid && in_ready) begin
            pend_valid_d = 1'b1;
            pend_data_d  = in_data;
        end
    end

    // NOTE: state registers use non-blocking assignments only, so every flop
    // samples its _d value from before the edge regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
        end
    end

endmodule : count_operand_buf

// File: rtl/count_dp.sv
// ----------------------------------------------------------------------------
// count_dp
//   Datapath of the set-bit counter. Buffers one operand, runs the
//   clear-lowest-set-bit loop (a <= a & (a-1)) as sequenced by count_ctrl, and
//   holds the popcount on a valid/ready result handshake.
//   Ports:
//     clk, rst               clock, asynchronous active-high reset
//     in_valid/in_data/in_ready     operand handshake
//     res_valid/res_data/res_ready  result handshake
//     state                  controller state (cnt_state_e)
//     start                  launch request to the controller
//     d                      working register nonzero (sampled in CHECK)
//     busy                   controller active or an operand is pending
// ----------------------------------------------------------------------------
module count_dp
    import count_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    output logic          in_ready,
    output logic          res_valid,
    output logic [CW-1:0] res_data,
    input  logic          res_ready,
    input  cnt_state_e    state,
    output logic          start,
    output logic          d,
    output logic          busy
);

    logic          pend_valid;
    logic [W-1:0]  pend_data;
    logic          launch;

    logic [W-1:0]  a_q,         a_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [CW-1:0] res_data_q,  res_data_d;

    count_operand_buf #(
        .W (W)
    ) u_operand_buf (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .pop        (launch),
        .pend_valid (pend_valid),
        .pend_data  (pend_data)
    );

    // Launch only when the result slot will be free by the time DONE writes
    // it; this is what lets DONE load res_* unconditionally.
    assign start  = (state == IDLE) && pend_valid && (!res_valid_q || res_ready);
    assign launch = start;

    assign d         = (a_q != '0);
    assign busy      = (state != IDLE) || pend_valid;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;

    // Working operand and running count.
    always_comb begin
        a_d   = a_q;
        cnt_d = cnt_q;
        if (launch) begin
            a_d   = pend_data;
            cnt_d = '0;
        end else if ((state == COUNT) && (a_q != '0)) begin
            // Clears exactly one set bit per COUNT visit; cnt tops out at W.
            a_d   = a_q & (a_q - W'(1));
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Result register: a DONE load takes priority over a same-cycle read.
    always_comb begin
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end
        if (state == DONE) begin
            res_valid_d = 1'b1;
            res_data_d  = cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q         <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            a_q         <= a_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule : count_dp

// File: tb/tb_count_dp.sv
// ----------------------------------------------------------------------------
// tb_count_dp
//   Directed bench for count_dp. A small behavioural controller drives
//   `state` from `start` and `d`; a negedge monitor records launches, result
//   rise times and accepted results.
// ----------------------------------------------------------------------------
module tb_count_dp;
    import count_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          res_valid;
    logic [CW-1:0] res_data;
    logic          res_ready = 1'b1;
    cnt_state_e    st;
    logic          start;
    logic          d;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    count_dp #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .state     (st),
        .start     (start),
        .d         (d),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Controller model.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= IDLE;
        end else begin
            case (st)
                IDLE:    if (start) st <= COUNT;
                COUNT:   st <= CHECK;
                CHECK:   st <= d ? COUNT : DONE;
                default: st <= IDLE;
            endcase
        end
    end

    // Monitor.
    int             cyc = 0;
    int             launch_cyc = 0;
    int             rise_cyc = 0;
    logic           res_valid_prev = 1'b0;
    logic [CW-1:0]  got_q[$];
    int             sim_seen = 0;
    int             sim_bad = 0;
    int             no_bubble = 0;
    logic           sim_prev = 1'b0;

    always_ff @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (sim_prev && in_ready) sim_bad++;
            sim_prev = start && in_valid && in_ready;
            if (sim_prev) sim_seen++;
            if (start) launch_cyc = cyc;
            if (start && res_valid && res_ready) no_bubble++;
            if (res_valid && !res_valid_prev) rise_cyc = cyc;
            if (res_valid && res_ready) got_q.push_back(res_data);
            res_valid_prev = res_valid;
        end else begin
            res_valid_prev = 1'b0;
            sim_prev       = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] v, input int budget);
        logic ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        check("send_accept", 32'(ok), 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input int budget);
        int i = 0;
        while ((got_q.size() < n) && (i < budget)) begin
            @(posedge clk);
            i++;
        end
        #1;
        check("result_count", 32'(got_q.size()), 32'(n));
    endtask

    typedef struct {
        logic [W-1:0] data;
        int           exp;
        int           lat;
    } vec_t;

    vec_t vecs[4] = '{
        '{8'hB5, 5, 12},
        '{8'h00, 0, 4},
        '{8'h80, 1, 4},
        '{8'hFF, 8, 18}
    };

    logic [CW-1:0] exp_q[$];
    logic          stream_done = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  32'(in_ready),  1);
        check("rst_res_valid", 32'(res_valid), 0);
        check("rst_res_data",  32'(res_data),  0);
        check("rst_start",     32'(start),     0);
        check("rst_d",         32'(d),         0);
        check("rst_busy",      32'(busy),      0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single operands with latency.
        res_ready = 1'b1;
        foreach (vecs[i]) begin
            got_q.delete();
            send(vecs[i].data, 20);
            wait_results(1, 60);
            check($sformatf("pop_%02h", vecs[i].data), 32'(got_q.size() > 0 ? got_q[0] : 4'hF), 32'(vecs[i].exp));
            check($sformatf("lat_%02h", vecs[i].data), 32'(rise_cyc - launch_cyc), 32'(vecs[i].lat));
            repeat (3) @(posedge clk);
            #1;
            check($sformatf("idle_%02h", vecs[i].data), 32'(busy), 0);
        end

        // Back-pressure.
        got_q.delete();
        sim_seen  = 0;
        sim_bad   = 0;
        no_bubble = 0;
        res_ready = 1'b0;
        send(8'h03, 20);
        send(8'h0F, 20);
        repeat (15) @(posedge clk);
        #1;
        check("bp_valid",    32'(res_valid), 1);
        check("bp_data",     32'(res_data),  2);
        repeat (5) @(posedge clk);
        #1;
        check("bp_hold",     32'(res_data),  2);
        check("bp_none_out", 32'(got_q.size()), 0);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) @(negedge clk);
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_busy",     32'(busy),     1);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(8'hFF, 50);
        wait_results(3, 100);
        repeat (20) @(posedge clk);
        #1;
        check("bp_no_dup", 32'(got_q.size()), 3);
        check("bp_r0", 32'(got_q.size() > 0 ? got_q[0] : 4'hF), 2);
        check("bp_r1", 32'(got_q.size() > 1 ? got_q[1] : 4'hF), 4);
        check("bp_r2", 32'(got_q.size() > 2 ? got_q[2] : 4'hF), 8);
        check("sim_accept_seen", 32'(sim_seen != 0), 1);
        check("sim_pend_kept",   32'(sim_bad), 0);
        check("no_bubble",       32'(no_bubble != 0), 1);

        // Asynchronous reset mid-operation.
        got_q.delete();
        send(8'hFF, 20);
        send(8'h0F, 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (st == COUNT) break;
        end
        check("rst_pre_state", 32'(st), 32'(COUNT));
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_ready",  32'(in_ready),  1);
        check("arst_res_valid", 32'(res_valid), 0);
        check("arst_res_data",  32'(res_data),  0);
        check("arst_start",     32'(start),     0);
        check("arst_d",         32'(d),         0);
        check("arst_busy",      32'(busy),      0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("arst_no_result", 32'(got_q.size()), 0);
        check("arst_idle",      32'(busy), 0);

        // Streaming with random back-pressure.
        got_q.delete();
        exp_q.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) begin
                    logic [W-1:0] v;
                    v = W'($urandom_range(0, 255));
                    exp_q.push_back(CW'($countones(v)));
                    send(v, 200);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        res_ready = 1'b1;
        wait_results(16, 1000);
        foreach (exp_q[i]) begin
            check($sformatf("stream_%0d", i), 32'(i < got_q.size() ? got_q[i] : 4'hF), 32'(exp_q[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_count_dp
